// File: rtl/sem_status_monitor_pkg.sv
// Shared definitions for the SEM controller status monitor: state encodings, widths, decode.
// Latency: none (types, constants and a pure combinational helper).
// Backpressure: none; the status interface is free-running and sampled every cycle.
package sem_status_monitor_pkg;

  localparam int SEM_STATE_W    = 3;
  localparam int HB_TIMEOUT_DEF = 4096;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [SEM_STATE_W-1:0] {
    SEM_IDLE     = 3'd0,
    SEM_INIT     = 3'd1,
    SEM_OBSERVE  = 3'd2,
    SEM_CORRECT  = 3'd3,
    SEM_CLASSIFY = 3'd4,
    SEM_INJECT   = 3'd5,
    SEM_FATAL    = 3'd7
  } sem_state_e;

  // Registered copy of the controller status pins that drive state and counting.
  typedef struct packed {
    logic initialization;
    logic observation;
    logic correction;
    logic classification;
    logic injection;
    logic heartbeat;
    logic uncorrectable;
  } sem_status_t;

  // The controller signals a fatal halt by raising all five state pins at once,
  // so that pattern must win over every single-pin state.
  function automatic sem_state_e sem_decode(input sem_status_t s);
    sem_state_e st;
    st = SEM_IDLE;
    if (s.initialization && s.observation && s.correction &&
        s.classification && s.injection) begin
      st = SEM_FATAL;
    end else if (s.initialization) begin
      st = SEM_INIT;
    end else if (s.injection) begin
      st = SEM_INJECT;
    end else if (s.correction) begin
      st = SEM_CORRECT;
    end else if (s.classification) begin
      st = SEM_CLASSIFY;
    end else if (s.observation) begin
      st = SEM_OBSERVE;
    end
    return st;
  endfunction

endpackage

// File: rtl/sem_sat_counter.sv
// Saturating event counter with a clear that can coincide with an increment.
// Latency: 1 cycle from inc/clr to cnt.
// Backpressure: none; holds at all-ones instead of wrapping.
module sem_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_icap,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // A clear that lands on an increment keeps that event, so the count restarts at 1.
  always_ff @(posedge clk_icap) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= W'(inc);
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/sem_status_monitor.sv
// Decodes SEM controller status, counts corrections, watches the heartbeat, raises alarms.
// Latency: 2 cycles pin-to-sem_state; sem_event/counters 1 cycle after the registered correction fall.
// Backpressure: none; status is sampled every clk_icap cycle. SEM_MON_ESSENTIAL_CNT_EN adds essential_cnt.
module sem_status_monitor
  import sem_status_monitor_pkg::*;
#(
  parameter int HB_TIMEOUT = HB_TIMEOUT_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                   clk_icap,
  input  logic                   reset,
  input  logic                   status_heartbeat,
  input  logic                   status_initialization,
  input  logic                   status_observation,
  input  logic                   status_correction,
  input  logic                   status_classification,
  input  logic                   status_injection,
  input  logic                   status_essential,
  input  logic                   status_uncorrectable,
  input  logic                   clr_counters,
  output logic [SEM_STATE_W-1:0] sem_state,
  output logic [CNT_W-1:0]       correction_cnt,
  output logic [CNT_W-1:0]       uncorrectable_cnt,
`ifdef SEM_MON_ESSENTIAL_CNT_EN
  output logic [CNT_W-1:0]       essential_cnt,
`endif
  output logic                   hb_timeout,
  output logic                   sem_event,
  output logic                   sem_alarm
);

  localparam int HB_W = $clog2(HB_TIMEOUT + 1);
  localparam logic [HB_W-1:0] HB_MAX = HB_W'(HB_TIMEOUT);

  sem_status_t s1_q;
  logic        s1_vld_q;
  logic        corr_prev_q;
  logic        armed_q;
  logic        completion;
  logic        inc_corr;
  logic        inc_unc;
  sem_state_e  state_q;
  sem_state_e  state_d;
  logic [HB_W-1:0] hb_cnt_q;
  logic [HB_W-1:0] hb_cnt_d;
  logic        hb_hit;
  logic        uncorr_seen_q;

  // Stage S1: one register on every status pin; everything downstream sees only these.
  always_ff @(posedge clk_icap) begin
    if (reset) begin
      s1_q     <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_q.initialization <= status_initialization;
      s1_q.observation    <= status_observation;
      s1_q.correction     <= status_correction;
      s1_q.classification <= status_classification;
      s1_q.injection      <= status_injection;
      s1_q.heartbeat      <= status_heartbeat;
      s1_q.uncorrectable  <= status_uncorrectable;
      s1_vld_q            <= 1'b1;
    end
  end

  // Completion tracking: a falling edge only counts once correction has been seen low
  // after reset, so a correction already running through reset is never counted.
  always_ff @(posedge clk_icap) begin
    if (reset) begin
      corr_prev_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      corr_prev_q <= s1_q.correction;
      armed_q     <= armed_q | (s1_vld_q & ~s1_q.correction);
    end
  end

  assign completion = armed_q & corr_prev_q & ~s1_q.correction;
  assign inc_corr   = completion & ~s1_q.uncorrectable;
  assign inc_unc    = completion &  s1_q.uncorrectable;

  // State register; FATAL is held until reset.
  always_ff @(posedge clk_icap) begin
    if (reset) begin
      state_q <= SEM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: decode the S1 pins unless already in FATAL.
  always_comb begin
    state_d = state_q;
    if (state_q != SEM_FATAL) begin
      state_d = sem_decode(s1_q);
    end
  end

  assign sem_state = state_q;

  // Heartbeat age: counts only in OBSERVE, restarts on a beat, parks at the limit.
  always_comb begin
    hb_cnt_d = hb_cnt_q;
    hb_hit   = 1'b0;
    if ((state_q != SEM_OBSERVE) || s1_q.heartbeat) begin
      hb_cnt_d = '0;
    end else if (hb_cnt_q != HB_MAX) begin
      hb_cnt_d = hb_cnt_q + HB_W'(1);
      hb_hit   = (hb_cnt_d == HB_MAX);
    end
  end

  // Heartbeat age register.
  always_ff @(posedge clk_icap) begin
    if (reset) begin
      hb_cnt_q <= '0;
    end else begin
      hb_cnt_q <= hb_cnt_d;
    end
  end

  // Sticky flags, event pulse and alarm; a new cause on the clear cycle survives the clear.
  always_ff @(posedge clk_icap) begin
    if (reset) begin
      hb_timeout    <= 1'b0;
      uncorr_seen_q <= 1'b0;
      sem_event     <= 1'b0;
      sem_alarm     <= 1'b0;
    end else begin
      hb_timeout    <= (hb_timeout & ~clr_counters) | hb_hit;
      uncorr_seen_q <= (uncorr_seen_q & ~clr_counters) | inc_unc;
      sem_event     <= completion;
      sem_alarm     <= hb_timeout | uncorr_seen_q | (state_q == SEM_FATAL);
    end
  end

  sem_sat_counter #(.W(CNT_W)) u_corr_cnt (
    .clk_icap (clk_icap),
    .reset    (reset),
    .inc      (inc_corr),
    .clr      (clr_counters),
    .cnt      (correction_cnt)
  );

  sem_sat_counter #(.W(CNT_W)) u_unc_cnt (
    .clk_icap (clk_icap),
    .reset    (reset),
    .inc      (inc_unc),
    .clr      (clr_counters),
    .cnt      (uncorrectable_cnt)
  );

`ifdef SEM_MON_ESSENTIAL_CNT_EN
  logic s1_essential_q;

  // Essential flag rides in S1 alongside the other status pins.
  always_ff @(posedge clk_icap) begin
    if (reset) begin
      s1_essential_q <= 1'b0;
    end else begin
      s1_essential_q <= status_essential;
    end
  end

  sem_sat_counter #(.W(CNT_W)) u_ess_cnt (
    .clk_icap (clk_icap),
    .reset    (reset),
    .inc      (completion & s1_essential_q),
    .clr      (clr_counters),
    .cnt      (essential_cnt)
  );
`else
  // status_essential has no consumer in this build.
  logic unused_essential;
  assign unused_essential = status_essential;
`endif

endmodule

// File: tb/tb_sem_status_monitor.sv
// Self-checking bench for sem_status_monitor: directed scenarios then randomized segments.
// Latency: expectations come from a sample-history reference model, compared every cycle.
// Backpressure: none; inputs change on the falling edge, outputs are checked there too.
module tb_sem_status_monitor;

  localparam int HB_T = 16;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk_icap;
  logic          reset;
  logic          status_heartbeat, status_initialization, status_observation;
  logic          status_correction, status_classification, status_injection;
  logic          status_essential, status_uncorrectable;
  logic          clr_counters;
  logic [2:0]    sem_state;
  logic [CW-1:0] correction_cnt, uncorrectable_cnt;
`ifdef SEM_MON_ESSENTIAL_CNT_EN
  logic [CW-1:0] essential_cnt;
`endif
  logic          hb_timeout, sem_event, sem_alarm;

  sem_status_monitor #(.HB_TIMEOUT(HB_T), .CNT_W(CW)) dut (
    .clk_icap              (clk_icap),
    .reset                 (reset),
    .status_heartbeat      (status_heartbeat),
    .status_initialization (status_initialization),
    .status_observation    (status_observation),
    .status_correction     (status_correction),
    .status_classification (status_classification),
    .status_injection      (status_injection),
    .status_essential      (status_essential),
    .status_uncorrectable  (status_uncorrectable),
    .clr_counters          (clr_counters),
    .sem_state             (sem_state),
    .correction_cnt        (correction_cnt),
    .uncorrectable_cnt     (uncorrectable_cnt),
`ifdef SEM_MON_ESSENTIAL_CNT_EN
    .essential_cnt         (essential_cnt),
`endif
    .hb_timeout            (hb_timeout),
    .sem_event             (sem_event),
    .sem_alarm             (sem_alarm)
  );

  initial clk_icap = 1'b0;
  always #5 clk_icap = ~clk_icap;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit init, obs, corr, cls, inj, hb, ess, unc;
  } smp_t;

  smp_t hist[$];   // pin samples taken since the last reset, oldest first
  bit   old_low;   // some sample already dropped from hist had correction low
  int   m_state, m_corr, m_unc, m_ess, m_age;
  bit   m_hbto, m_useen, m_event, m_alarm;

  function automatic int ref_decode(input smp_t s);
    if (s.init && s.obs && s.corr && s.cls && s.inj) return 7;
    if (s.init) return 1;
    if (s.inj)  return 5;
    if (s.corr) return 3;
    if (s.cls)  return 4;
    if (s.obs)  return 2;
    return 0;
  endfunction

  function automatic int bump(input int v, input bit clr, input bit inc);
    if (clr) return inc ? 1 : 0;
    if (inc && v < CMAX) return v + 1;
    return v;
  endfunction

  // One clock edge: p is what the pins held during the cycle that just ended.
  task automatic model_step(input smp_t p, input bit rst, input bit clr);
    smp_t cur, prev, zero, gone;
    bit   armed, comp, hit;
    int   n;
    zero = '{default: 0};
    if (rst) begin
      hist.delete();
      old_low = 0;
      m_state = 0; m_corr = 0; m_unc = 0; m_ess = 0; m_age = 0;
      m_hbto = 0; m_useen = 0; m_event = 0; m_alarm = 0;
      return;
    end
    n    = hist.size();
    cur  = (n >= 1) ? hist[n-1] : zero;
    prev = (n >= 2) ? hist[n-2] : zero;
    // A correction counts only if correction was seen low after reset before it rose.
    armed = old_low;
    for (int i = 0; i <= n - 3; i++) if (!hist[i].corr) armed = 1;
    comp = (n >= 2) && prev.corr && !cur.corr && armed;
    m_alarm = m_hbto || m_useen || (m_state == 7);
    hit = 0;
    if (m_state != 2 || cur.hb) m_age = 0;
    else if (m_age < HB_T) begin
      m_age++;
      hit = (m_age == HB_T);
    end
    m_hbto  = (m_hbto && !clr) || hit;
    m_useen = (m_useen && !clr) || (comp && cur.unc);
    m_corr  = bump(m_corr, clr, comp && !cur.unc);
    m_unc   = bump(m_unc,  clr, comp &&  cur.unc);
    m_ess   = bump(m_ess,  clr, comp &&  cur.ess);
    m_event = comp;
    if (m_state != 7) m_state = ref_decode(cur);
    hist.push_back(p);
    if (hist.size() > 6) begin
      gone = hist.pop_front();
      if (!gone.corr) old_low = 1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    smp_t p;
    p.init = status_initialization; p.obs = status_observation;
    p.corr = status_correction;     p.cls = status_classification;
    p.inj  = status_injection;      p.hb  = status_heartbeat;
    p.ess  = status_essential;      p.unc = status_uncorrectable;
    @(posedge clk_icap);
    model_step(p, reset, clr_counters);
    @(negedge clk_icap);
    chk("sem_state",         32'(sem_state),         32'(m_state));
    chk("correction_cnt",    32'(correction_cnt),    32'(m_corr));
    chk("uncorrectable_cnt", 32'(uncorrectable_cnt), 32'(m_unc));
    chk("hb_timeout",        32'(hb_timeout),        32'(m_hbto));
    chk("sem_event",         32'(sem_event),         32'(m_event));
    chk("sem_alarm",         32'(sem_alarm),         32'(m_alarm));
`ifdef SEM_MON_ESSENTIAL_CNT_EN
    chk("essential_cnt",     32'(essential_cnt),     32'(m_ess));
`endif
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic run_hb(input int n, input int period);
    for (int k = 0; k < n; k++) begin
      status_heartbeat = ((k % period) == (period - 1));
      cyc();
    end
    status_heartbeat = 1'b0;
  endtask

  task automatic set_st(input bit i, input bit o, input bit c, input bit cl, input bit j);
    status_initialization = i; status_observation = o; status_correction = c;
    status_classification = cl; status_injection = j;
  endtask

  task automatic pulse_clr();
    clr_counters = 1'b1;
    cyc();
    clr_counters = 1'b0;
  endtask

  int ev;
  int seg_len;

  initial begin
    reset = 1'b1; clr_counters = 1'b0;
    status_heartbeat = 1'b0; status_essential = 1'b0; status_uncorrectable = 1'b0;
    set_st(0, 0, 0, 0, 0);
    run(3);
    chk("rst_state", 32'(sem_state), 32'd0);
    chk("rst_alarm", 32'(sem_alarm), 32'd0);
    reset = 1'b0;
    run(3);

    // INIT then OBSERVE, each visible two cycles after the pin edge
    status_initialization = 1'b1;
    cyc(); chk("init_lat1", 32'(sem_state), 32'd0);
    cyc(); chk("init_lat2", 32'(sem_state), 32'd1);
    run(8);
    status_initialization = 1'b0; status_observation = 1'b1;
    cyc(); chk("obs_lat1", 32'(sem_state), 32'd1);
    cyc(); chk("obs_lat2", 32'(sem_state), 32'd2);
    chk("obs_cnt_zero", 32'(correction_cnt), 32'd0);
    run_hb(6, 4);

    // correctable correction: one event, count 1, no alarm
    ev = 0;
    status_correction = 1'b1;
    for (int k = 0; k < 5; k++) begin cyc(); ev += int'(sem_event); end
    status_correction = 1'b0;
    for (int k = 0; k < 6; k++) begin cyc(); ev += int'(sem_event); end
    chk("corr_cnt",    32'(correction_cnt), 32'd1);
    chk("corr_events", 32'(ev),             32'd1);
    chk("corr_alarm",  32'(sem_alarm),      32'd0);

    // uncorrectable correction raises the alarm; clr_counters clears it
    status_uncorrectable = 1'b1; status_correction = 1'b1;
    run(5);
    status_correction = 1'b0;
    run(2);
    status_uncorrectable = 1'b0;
    run(3);
    chk("unc_cnt",   32'(uncorrectable_cnt), 32'd1);
    chk("unc_alarm", 32'(sem_alarm),         32'd1);
    pulse_clr();
    run(2);
    chk("clr_corr",  32'(correction_cnt),    32'd0);
    chk("clr_unc",   32'(uncorrectable_cnt), 32'd0);
    chk("clr_alarm", 32'(sem_alarm),         32'd0);

    // heartbeat loss: timeout 16 cycles into OBSERVE
    status_observation = 1'b0;
    run(3);
    status_observation = 1'b1;
    run(2);
    run(15);
    chk("hb_before", 32'(hb_timeout), 32'd0);
    cyc();
    chk("hb_at16", 32'(hb_timeout), 32'd1);
    run(2);
    chk("hb_alarm", 32'(sem_alarm), 32'd1);
    pulse_clr();
    run_hb(50, 10);
    chk("hb_kept", 32'(hb_timeout), 32'd0);
    chk("hb_kept_alarm", 32'(sem_alarm), 32'd0);

    // saturation with a 4-bit counter, then clear coincident with a completion
    pulse_clr();
    for (int k = 0; k < 20; k++) begin
      status_correction = 1'b1; run(3);
      status_correction = 1'b0; run(3);
    end
    chk("sat", 32'(correction_cnt), 32'd15);
    status_correction = 1'b1; run(3);
    status_correction = 1'b0; cyc();
    pulse_clr();
    chk("clr_coinc", 32'(correction_cnt), 32'd1);
    chk("clr_coinc_unc", 32'(uncorrectable_cnt), 32'd0);

    // reset mid-correction: that correction is never counted
    status_correction = 1'b1; run(3);
    reset = 1'b1; run(2);
    reset = 1'b0; run(3);
    status_correction = 1'b0; run(5);
    chk("rst_discard", 32'(correction_cnt), 32'd0);

    // FATAL is absorbing; only reset leaves it
    set_st(1, 1, 1, 1, 1);
    run(3);
    chk("fatal", 32'(sem_state), 32'd7);
    set_st(0, 0, 0, 0, 0);
    run(10);
    chk("fatal_hold",  32'(sem_state), 32'd7);
    chk("fatal_alarm", 32'(sem_alarm), 32'd1);
    pulse_clr();
    chk("fatal_clr", 32'(sem_state), 32'd7);
    reset = 1'b1; run(2);
    reset = 1'b0; run(2);
    chk("fatal_reset", 32'(sem_state), 32'd0);

    // randomized segments
    for (int s = 0; s < 300; s++) begin
      seg_len = $urandom_range(1, 8);
      reset = ($urandom_range(0, 39) == 0);
      status_initialization = ($urandom_range(0, 7) == 0);
      status_observation    = ($urandom_range(0, 3) != 0);
      status_correction     = ($urandom_range(0, 1) == 1);
      status_classification = ($urandom_range(0, 3) == 0);
      status_injection      = ($urandom_range(0, 7) == 0);
      status_uncorrectable  = ($urandom_range(0, 2) == 0);
      status_essential      = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < seg_len; k++) begin
        status_heartbeat = ($urandom_range(0, 5) == 0);
        clr_counters     = ($urandom_range(0, 24) == 0);
        cyc();
      end
    end
    reset = 1'b0; clr_counters = 1'b0; status_heartbeat = 1'b0;
    status_uncorrectable = 1'b0; status_essential = 1'b0;
    set_st(0, 0, 0, 0, 0);
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sem_status_monitor.md
SEM_STATUS_MONITOR -- requirements
Module: sem_status_monitor

Interface
- REQ-001 Parameter HB_TIMEOUT, default 4096: clk_icap cycles without heartbeat in OBSERVE before timeout.
- REQ-002 Parameter CNT_W, default 16: width of event counters.
- REQ-003 clk_icap  in  1  single clock, the same ICAP clock that drives the SEM controller.
- REQ-004 reset  in  1  synchronous, active-high reset.
- REQ-005 status_heartbeat, status_initialization, status_observation, status_correction, status_classification, status_injection, status_essential, status_uncorrectable  in  1 each  SEM controller status interface, synchronous to clk_icap.
- REQ-006 clr_counters  in  1  single-cycle pulse; clears counters and sticky flags.
- REQ-007 sem_state  out  3  decoded controller state: 0 IDLE, 1 INIT, 2 OBSERVE, 3 CORRECT, 4 CLASSIFY, 5 INJECT, 7 FATAL.
- REQ-008 correction_cnt  out  CNT_W  completed correctable corrections.
- REQ-009 uncorrectable_cnt  out  CNT_W  completed corrections flagged uncorrectable.
- REQ-010 hb_timeout  out  1  sticky heartbeat-loss flag.
- REQ-011 sem_event  out  1  one-cycle pulse per completed correction cycle.
- REQ-012 sem_alarm  out  1  hb_timeout OR uncorrectable seen (sticky) OR FATAL.

Function
- REQ-013 All status inputs SHALL be registered once (stage S1); all logic SHALL operate on S1 values.
- REQ-014 Decode priority SHALL be: FATAL (initialization, observation, correction, classification and injection all high), INIT, INJECT, CORRECT, CLASSIFY, OBSERVE, otherwise IDLE.
- REQ-015 sem_state SHALL be registered and SHALL reflect an input change exactly 2 cycles after it appears at the ports.
- REQ-016 FATAL SHALL be absorbing; only reset leaves it.
- REQ-017 A completed correction SHALL be the S1 falling edge of status_correction; sem_event SHALL pulse in the following cycle.
- REQ-018 On completion: if S1 status_uncorrectable is high, increment uncorrectable_cnt and set uncorr_seen; else increment correction_cnt.
- REQ-019 Counters SHALL saturate at 2^CNT_W-1, with no wrap.
- REQ-020 The heartbeat counter SHALL run only while sem_state is OBSERVE, SHALL clear on each S1 heartbeat pulse, and SHALL hold at 0 in other states.
- REQ-021 When the heartbeat counter reaches HB_TIMEOUT, hb_timeout SHALL set in that cycle and the counter SHALL stop.
- REQ-022 When clr_counters coincides with a completion, the affected counter SHALL become 1 and the others 0.
- REQ-023 clr_counters SHALL clear hb_timeout and uncorr_seen but SHALL NOT clear FATAL or the state.
- REQ-024 sem_alarm SHALL be registered, one cycle after its cause.

Reset
- REQ-025 Reset SHALL set sem_state=IDLE, clear both counters, clear hb_timeout, sem_event, sem_alarm, uncorr_seen and the heartbeat counter, and clear the S1 registers.
- REQ-026 Reset asserted mid-correction SHALL discard that correction; no completion is counted for it after reset.

Configuration
- REQ-027 Macro SEM_MON_ESSENTIAL_CNT_EN SHALL control essential-error counting.
- REQ-028 With SEM_MON_ESSENTIAL_CNT_EN defined, add output essential_cnt [CNT_W]. It SHALL increment on completions where S1 status_essential is high, saturate, and clear with clr_counters and reset.
- REQ-029 Without SEM_MON_ESSENTIAL_CNT_EN, no essential_cnt port or logic SHALL exist, and status_essential SHALL be unused.

Structure
- REQ-030 A shared package SHALL hold the sem_state encodings (IDLE..FATAL), the state width (3) and the default HB_TIMEOUT and CNT_W.
- REQ-031 Sub-module sem_sat_counter (CNT_W-wide, inc/clr, saturating) SHALL be instantiated per counter.

Verification
- REQ-032 Scenario: reset, then initialization high 10 cycles, then observation high -> sem_state 1, then 2, each 2 cycles after the input edge; counters 0.
- REQ-033 Scenario: in OBSERVE, correction high 5 cycles with uncorrectable low -> correction_cnt=1, one sem_event pulse, sem_alarm=0.
- REQ-034 Scenario: correction with uncorrectable high -> uncorrectable_cnt=1, sem_alarm=1; a later clr_counters clears both.
- REQ-035 Scenario: HB_TIMEOUT=16, OBSERVE with no heartbeat -> hb_timeout=1 at cycle 16; with heartbeats every 10 cycles -> stays 0.
- REQ-036 Scenario: all five state inputs high -> sem_state=7; dropping the inputs keeps 7 until reset.
- REQ-037 Scenario: CNT_W=4, 20 corrections -> correction_cnt=15; clr_counters coincident with a completion -> 1.
